// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, arbiter states and the default refresh interval.
package sdram_pkg;

  localparam int REF_PERIOD_DEF = 390;

  // Command encoding is {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval counter with a sticky refresh-pending flag.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clr,
  output logic pending
);

  localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(REF_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A wrap landing on the same edge as the clear wins, so no refresh is ever dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (wrap) begin
      pending <= 1'b1;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: sequences init, periodic auto-refresh and round-robin write/read grants.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  output logic              aref_en,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  output logic              wr_en,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_ba,
  input  logic              rd_req,
  output logic              rd_en,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_ba,
  output logic              ref_break,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [1:0]        sdram_ba
);

  state_t state, next_state;
  logic   pending;
  logic   last_wr;
  logic   go_aref, go_write, go_read;

  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (state != ST_INIT),
    .clr     (go_aref),
    .pending (pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Refresh beats any request; simultaneous requests alternate against last_wr.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_INIT:  if (init_end) next_state = ST_IDLE;
      ST_IDLE: begin
        if (pending)                 next_state = ST_AREF;
        else if (wr_req && rd_req)   next_state = last_wr ? ST_READ : ST_WRITE;
        else if (wr_req)             next_state = ST_WRITE;
        else if (rd_req)             next_state = ST_READ;
      end
      ST_AREF:  if (aref_end) next_state = ST_IDLE;
      ST_WRITE: if (wr_end)   next_state = ST_IDLE;
      ST_READ:  if (rd_end)   next_state = ST_IDLE;
      default:  next_state = ST_INIT;
    endcase
  end

  assign go_aref  = (state == ST_IDLE) && (next_state == ST_AREF);
  assign go_write = (state == ST_IDLE) && (next_state == ST_WRITE);
  assign go_read  = (state == ST_IDLE) && (next_state == ST_READ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_wr   <= 1'b0;
      aref_en   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      sdram_cke <= 1'b0;
    end else begin
      aref_en   <= go_aref;
      wr_en     <= go_write;
      rd_en     <= go_read;
      sdram_cke <= 1'b1;
      if (go_write) last_wr <= 1'b1;
      else if (go_read) last_wr <= 1'b0;
    end
  end

  assign ref_break = pending && ((state == ST_WRITE) || (state == ST_READ));

  // Reset gates the bus directly so it reads NOP the instant rst rises, not at the next edge.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_ba   = 2'b00;
    if (!rst) begin
      unique case (state)
        ST_INIT: begin
          sdram_cmd  = init_cmd;
          sdram_addr = init_addr;
        end
        ST_AREF: begin
          sdram_cmd  = aref_cmd;
          sdram_addr = aref_addr;
        end
        ST_WRITE: begin
          sdram_cmd  = wr_cmd;
          sdram_addr = wr_addr;
          sdram_ba   = wr_ba;
        end
        ST_READ: begin
          sdram_cmd  = rd_cmd;
          sdram_addr = rd_addr;
          sdram_ba   = rd_ba;
        end
        default: begin
          sdram_cmd  = CMD_NOP;
          sdram_addr = '0;
          sdram_ba   = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameter REF_PERIOD, default 390, meaning refresh interval in clk cycles (7.8 us at 50 MHz).
REQ-002 SHALL have parameter ADDR_W, default 13, meaning SDRAM address width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports: clk input 1, system clock; rst input 1, async active-high reset.
REQ-004 SHALL have init_end input 1, init sequence complete; init_cmd input 4, init command; init_addr input ADDR_W, init address.
REQ-005 SHALL have aref_en output 1, refresh start pulse; aref_end input 1, refresh done; aref_cmd input 4; aref_addr input ADDR_W.
REQ-006 SHALL have wr_req input 1; wr_en output 1, write grant pulse; wr_end input 1; wr_cmd input 4; wr_addr input ADDR_W; wr_ba input 2.
REQ-007 SHALL have rd_req input 1; rd_en output 1, read grant pulse; rd_end input 1; rd_cmd input 4; rd_addr input ADDR_W; rd_ba input 2.
REQ-008 SHALL have ref_break output 1, a refresh is pending, so the active burst engine terminates at its next burst boundary.
REQ-009 SHALL have sdram_cke output 1; sdram_cmd output 4 ({cs_n,ras_n,cas_n,we_n}); sdram_addr output ADDR_W; sdram_ba output 2.

Function
REQ-010 SHALL implement states INIT, IDLE, AREF, WRITE, READ in a registered state register.
REQ-011 SHALL go INIT->IDLE on the cycle after init_end=1.
REQ-012 SHALL hold the refresh counter at 0 in INIT, then count 0..REF_PERIOD-1 and wrap.
REQ-013 SHALL set the refresh-pending flag on each wrap and clear it on entry to AREF; a wrap while the flag is already set leaves it set, with no queued second refresh.
REQ-014 SHALL apply IDLE priority: pending refresh > write/read; entry into the chosen state takes one cycle.
REQ-015 SHALL resolve wr_req and rd_req when both are high in IDLE by round-robin against a last-granted flag, which resets to "read" so that write wins first; a lone request is always granted.
REQ-016 SHALL assert aref_en/wr_en/rd_en as a registered single-cycle pulse during the first cycle of AREF/WRITE/READ respectively.
REQ-017 SHALL return AREF/WRITE/READ to IDLE on the cycle after aref_end/wr_end/rd_end respectively; IDLE lasts at least one cycle (NOP) between operations.
REQ-018 SHALL ignore any *_end input not matching the current state.
REQ-019 SHALL drive ref_break = refresh-pending flag AND state in {WRITE, READ}.
REQ-020 SHALL select sdram_cmd/addr/ba combinationally by state: INIT->init_*, AREF->aref_*, WRITE->wr_*, READ->rd_*, ba=0 for INIT/AREF, IDLE->NOP 4'b0111, addr 0, ba 0.
REQ-021 SHALL register sdram_cke: 0 in reset, 1 from the first clock after reset deassertion.
REQ-022 SHALL leave requests that are not granted pending; requesters hold req high until they receive en.

Reset
REQ-023 SHALL, on rst=1, immediately force: state INIT, counter 0, pending 0, last-granted "read", all *_en 0, ref_break 0, sdram_cke 0, sdram_cmd NOP, sdram_addr 0, sdram_ba 0.
REQ-024 SHALL abandon any in-flight operation when reset is asserted mid-operation, with no completion pulse; the block restarts at INIT.

Structure
REQ-025 SHALL take from shared package sdram_pkg: command encodings (NOP 0111, PRE 0010, AREF 0001, ACT 0011, WR 0100, RD 0101, MRS 0000), the state enumeration, and the REF_PERIOD default.
REQ-026 SHALL place the refresh counter and pending flag in sub-module sdram_ref_timer (inputs clk, rst, enable, clr; output pending).

Verification
REQ-027 SHALL test: reset, init_end pulse at cycle 100 -> IDLE at cycle 101, counter starts, sdram_cmd=0111 in IDLE.
REQ-028 SHALL test: idle for REF_PERIOD=390 cycles -> aref_en pulse once, sdram_cmd follows aref_cmd, IDLE the cycle after aref_end.
REQ-029 SHALL test: wr_req and rd_req held high together -> grants wr, rd, wr, rd in order, each separated by at least one NOP cycle.
REQ-030 SHALL test: long write with refresh wrap mid-burst -> ref_break=1 until wr_end; next state AREF despite rd_req=1.
REQ-031 SHALL test: refresh pending while wr_req is high in IDLE -> AREF first, then WRITE.
REQ-032 SHALL test: rst asserted in WRITE -> same-delta outputs NOP/0/0, cke 0, wr_en never re-pulses until a new init_end.
